// File: rtl/alu_seq_pkg.sv
// Shared opcode, FSM state and ALU control encodings for the sequenced ALU controller.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_RSUB = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_OR   = 3'd5,
    OP_PASS = 3'd6,
    OP_MUL  = 3'd7
  } opcode_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Bit positions inside the 5-bit ALU control word {InvA,InvB,cIn,ORen,FloodCarry}.
  localparam int CTRL_INVA  = 4;
  localparam int CTRL_INVB  = 3;
  localparam int CTRL_CIN   = 2;
  localparam int CTRL_OREN  = 1;
  localparam int CTRL_FLOOD = 0;

  localparam logic [4:0] CTRL_ADD  = 5'b00000;
  localparam logic [4:0] CTRL_SUB  = (5'b1 << CTRL_INVB) | (5'b1 << CTRL_CIN);
  localparam logic [4:0] CTRL_RSUB = (5'b1 << CTRL_INVA) | (5'b1 << CTRL_CIN);
  localparam logic [4:0] CTRL_INC  = (5'b1 << CTRL_CIN);
  localparam logic [4:0] CTRL_DEC  = (5'b1 << CTRL_INVB);
  localparam logic [4:0] CTRL_OR   = (5'b1 << CTRL_OREN);
  localparam logic [4:0] CTRL_PASS = 5'b00000;

  function automatic logic [4:0] op_ctrl(input opcode_e op);
    logic [4:0] ctrl;
    ctrl = 5'b00000;
    case (op)
      OP_ADD:  ctrl = CTRL_ADD;
      OP_SUB:  ctrl = CTRL_SUB;
      OP_RSUB: ctrl = CTRL_RSUB;
      OP_INC:  ctrl = CTRL_INC;
      OP_DEC:  ctrl = CTRL_DEC;
      OP_OR:   ctrl = CTRL_OR;
      OP_PASS: ctrl = CTRL_PASS;
      default: ctrl = 5'b00000;
    endcase
    return ctrl;
  endfunction

  // INC, DEC and PASS present a zero B operand to the adder.
  function automatic logic op_uses_b(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_RSUB) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-requester round-robin arbiter; the priority pointer moves away from each accepted grant.
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic prio_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = req[gi] & (~req[1-gi] | (prio_reg == 1'(gi)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= 1'b0;
    end else if (accept) begin
      prio_reg <= grant[0];
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer sharing one external ripple-carry ALU between two requesters.
// Define ALU_SEQ_CTRL_MUL_EN to make opcode 7 a shift-add multiply; otherwise it is reported as illegal.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int BitWidth = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2:0]          req0_op,
  input  logic [2:0]          req1_op,
  input  logic [BitWidth-1:0] req0_a,
  input  logic [BitWidth-1:0] req0_b,
  input  logic [BitWidth-1:0] req1_a,
  input  logic [BitWidth-1:0] req1_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [BitWidth-1:0] rsp_data,
  output logic                rsp_cout,
  output logic                rsp_zero,
  output logic                rsp_ovf,
  output logic                rsp_err,
  output logic [4:0]          alu_ctrl,
  output logic [BitWidth-1:0] alu_dina,
  output logic [BitWidth-1:0] alu_dinb,
  input  logic [BitWidth-1:0] alu_dout,
  input  logic                alu_cout,
  input  logic                alu_zero,
  input  logic                alu_ovf,
  output logic                busy
);

  logic [1:0]          state_reg;
  opcode_e             op_reg;
  logic [BitWidth-1:0] a_reg;
  logic [BitWidth-1:0] b_reg;
  logic                id_reg;

  logic                rsp_valid_reg;
  logic                rsp_id_reg;
  logic [BitWidth-1:0] rsp_data_reg;
  logic                rsp_cout_reg;
  logic                rsp_zero_reg;
  logic                rsp_ovf_reg;
  logic                rsp_err_reg;

  logic [1:0]          grant;
  logic                accept;
  logic                sel;
  opcode_e             sel_op;
  logic [BitWidth-1:0] sel_a;
  logic [BitWidth-1:0] sel_b;

  alu_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  // Ready is gated by reset so nothing can transfer in the reset cycle.
  assign req_ready = (state_reg == ST_IDLE && !rst) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sel       = grant[1];
  assign sel_op    = sel ? opcode_e'(req1_op) : opcode_e'(req0_op);
  assign sel_a     = sel ? req1_a : req0_a;
  assign sel_b     = sel ? req1_b : req0_b;

  assign busy      = (state_reg != ST_IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_cout  = rsp_cout_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign rsp_ovf   = rsp_ovf_reg;
  assign rsp_err   = rsp_err_reg;

`ifdef ALU_SEQ_CTRL_MUL_EN
  localparam int CntW = $clog2(BitWidth) + 1;

  logic [BitWidth-1:0] acc_reg;
  logic [BitWidth-1:0] mcand_reg;
  logic [BitWidth-1:0] mplier_reg;
  logic [CntW-1:0]     cnt_reg;
  logic                ovf_reg;
  logic                mul_ovf_step;
  logic                mul_last;

  // A lost mcand bit only matters if a remaining multiplier bit would still add it in.
  assign mul_ovf_step = (mplier_reg[0] & alu_cout) |
                        (mcand_reg[BitWidth-1] & ((mplier_reg >> 1) != '0));
  assign mul_last     = (cnt_reg == CntW'(BitWidth - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else if (accept) begin
      acc_reg    <= '0;
      mcand_reg  <= sel_a;
      mplier_reg <= sel_b;
      cnt_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else if (state_reg == ST_MUL) begin
      acc_reg    <= alu_dout;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CntW'(1);
      ovf_reg    <= ovf_reg | mul_ovf_step;
    end
  end
`endif

  always_comb begin
    alu_ctrl = 5'b00000;
    alu_dina = '0;
    alu_dinb = '0;
    if (state_reg == ST_EXEC && op_reg != OP_MUL) begin
      alu_ctrl = op_ctrl(op_reg);
      alu_dina = a_reg;
      alu_dinb = op_uses_b(op_reg) ? b_reg : '0;
    end
`ifdef ALU_SEQ_CTRL_MUL_EN
    if (state_reg == ST_MUL) begin
      alu_ctrl = CTRL_ADD;
      alu_dina = acc_reg;
      alu_dinb = mplier_reg[0] ? mcand_reg : '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_ADD;
      a_reg         <= '0;
      b_reg         <= '0;
      id_reg        <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_cout_reg  <= 1'b0;
      rsp_zero_reg  <= 1'b0;
      rsp_ovf_reg   <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg <= sel_op;
            a_reg  <= sel_a;
            b_reg  <= sel_b;
            id_reg <= sel;
`ifdef ALU_SEQ_CTRL_MUL_EN
            state_reg <= (sel_op == OP_MUL) ? ST_MUL : ST_EXEC;
`else
            state_reg <= ST_EXEC;
`endif
          end
        end
        ST_EXEC: begin
          rsp_valid_reg <= 1'b1;
          rsp_id_reg    <= id_reg;
          // Only reachable with opcode 7 when the multiplier is compiled out.
          if (op_reg == OP_MUL) begin
            rsp_data_reg <= '0;
            rsp_cout_reg <= 1'b0;
            rsp_zero_reg <= 1'b0;
            rsp_ovf_reg  <= 1'b0;
            rsp_err_reg  <= 1'b1;
          end else begin
            rsp_data_reg <= alu_dout;
            rsp_cout_reg <= alu_cout;
            rsp_zero_reg <= alu_zero;
            rsp_ovf_reg  <= alu_ovf;
            rsp_err_reg  <= 1'b0;
          end
          state_reg <= ST_RESP;
        end
`ifdef ALU_SEQ_CTRL_MUL_EN
        ST_MUL: begin
          if (mul_last) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= id_reg;
            rsp_data_reg  <= alu_dout;
            rsp_cout_reg  <= 1'b0;
            rsp_zero_reg  <= (alu_dout == '0);
            rsp_ovf_reg   <= ovf_reg | mul_ovf_step;
            rsp_err_reg   <= 1'b0;
            state_reg     <= ST_RESP;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural RCA ALU, arithmetic reference model and a response scoreboard.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_data;
  logic         rsp_cout, rsp_zero, rsp_ovf, rsp_err;
  logic [4:0]   alu_ctrl;
  logic [W-1:0] alu_dina, alu_dinb, alu_dout;
  logic         alu_cout, alu_zero, alu_ovf;
  logic         busy;

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic         cout;
    logic         zero;
    logic         ovf;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prio_model;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_ctrl #(.BitWidth(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_op   (req0_op),
    .req1_op   (req1_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_zero  (rsp_zero),
    .rsp_ovf   (rsp_ovf),
    .rsp_err   (rsp_err),
    .alu_ctrl  (alu_ctrl),
    .alu_dina  (alu_dina),
    .alu_dinb  (alu_dinb),
    .alu_dout  (alu_dout),
    .alu_cout  (alu_cout),
    .alu_zero  (alu_zero),
    .alu_ovf   (alu_ovf),
    .busy      (busy)
  );

  // Ripple-carry ALU driven by {InvA,InvB,cIn,ORen,FloodCarry}.
  logic [W-1:0] am, bm;
  logic [W:0]   full;
  always_comb begin
    am   = alu_ctrl[4] ? ~alu_dina : alu_dina;
    bm   = alu_ctrl[3] ? ~alu_dinb : alu_dinb;
    full = {1'b0, am} + {1'b0, bm} + {{W{1'b0}}, alu_ctrl[2]};
    if (alu_ctrl[1]) begin
      alu_dout = am | bm;
      alu_cout = 1'b0;
      alu_ovf  = 1'b0;
    end else begin
      alu_dout = full[W-1:0];
      alu_cout = full[W];
      alu_ovf  = (am[W-1] == bm[W-1]) && (full[W-1] != am[W-1]);
    end
    alu_zero = (alu_dout == '0);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [2:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ua, ub, sa, sbv, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sbv = int'($signed(b));
    ur = 0;
    sr = 0;
    e.id = id; e.cout = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 2;
    case (op)
      3'd0: begin ur = ua + ub; sr = sa + sbv; e.cout = (ur >= (1 << W)); end
      3'd1: begin ur = ua - ub; sr = sa - sbv; e.cout = (ua >= ub); end
      3'd2: begin ur = ub - ua; sr = sbv - sa; e.cout = (ub >= ua); end
      3'd3: begin ur = ua + 1;  sr = sa + 1;   e.cout = (ur >= (1 << W)); end
      3'd4: begin ur = ua - 1;  sr = sa - 1;   e.cout = (ua != 0); end
      3'd5: ur = ua | ub;
      3'd6: ur = ua;
      default: ur = ua * ub;
    endcase
    e.data = ur[W-1:0];
    if (op <= 3'd4) e.ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    e.zero = (e.data == '0);
    if (op == 3'd7) begin
`ifdef ALU_SEQ_CTRL_MUL_EN
      e.ovf = (ur >= (1 << W));
      e.lat = W + 1;
`else
      e.data = '0;
      e.zero = 1'b0;
      e.err  = 1'b1;
`endif
    end
    return e;
  endfunction

  task automatic set_req(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin
      req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_op = op; req1_a = a; req1_b = b;
    end
    req_valid[id] = 1'b1;
  endtask

  // Called at posedge+1: predicts the grant, pushes the expectation, then pops it at the response.
  task automatic serve(input int hold);
    exp_t e, got_e;
    logic [1:0] pred;
    int gid, w, n_acc;
    pred = (req_valid == 2'b11) ? (prio_model ? 2'b10 : 2'b01) : req_valid;
    gid  = pred[1] ? 1 : 0;
    e = (gid == 1) ? model(1'b1, req1_op, req1_a, req1_b) : model(1'b0, req0_op, req0_a, req0_b);
    sb.push_back(e);
    w = 0;
    @(negedge clk);
    while ((req_valid & req_ready) == 2'b00 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_val("accept_seen", {31'b0, (req_valid & req_ready) != 2'b00}, 1);
    if ((req_valid & req_ready) == 2'b00) begin
      sb.delete();
      req_valid = 2'b00;
      return;
    end
    check_val("req_ready", {30'b0, req_ready}, {30'b0, pred});
    n_acc = cyc;
    @(posedge clk); #1;
    req_valid[gid] = 1'b0;
    prio_model = (gid == 0);
    w = 0;
    @(negedge clk);
    while (!rsp_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    check_val("rsp_seen", {31'b0, rsp_valid}, 1);
    if (!rsp_valid) begin
      sb.delete();
      return;
    end
    check_val("latency", cyc - n_acc, e.lat);
    for (int k = 0; k < hold; k++) begin
      check_val("hold_valid", {31'b0, rsp_valid}, 1);
      check_val("hold_data", {28'b0, rsp_data}, {28'b0, e.data});
      check_val("hold_id", {31'b0, rsp_id}, {31'b0, e.id});
      check_val("hold_req_ready", {30'b0, req_ready}, 0);
      @(negedge clk);
    end
    got_e = sb.pop_front();
    check_val("rsp_id", {31'b0, rsp_id}, {31'b0, got_e.id});
    check_val("rsp_data", {28'b0, rsp_data}, {28'b0, got_e.data});
    check_val("rsp_cout", {31'b0, rsp_cout}, {31'b0, got_e.cout});
    check_val("rsp_zero", {31'b0, rsp_zero}, {31'b0, got_e.zero});
    check_val("rsp_ovf", {31'b0, rsp_ovf}, {31'b0, got_e.ovf});
    check_val("rsp_err", {31'b0, rsp_err}, {31'b0, got_e.err});
    $display("txn id=%0d data=%0h cout=%0d zero=%0d ovf=%0d err=%0d lat=%0d",
             rsp_id, rsp_data, rsp_cout, rsp_zero, rsp_ovf, rsp_err, cyc - n_acc);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_val("rsp_drop", {31'b0, rsp_valid}, 0);
    check_val("idle_busy", {31'b0, busy}, 0);
  endtask

  // Accept a request from requester 0, then assert reset two cycles later (MUL cycle 2 or RESP).
  task automatic abort_txn(input logic [2:0] op);
    int w;
    set_req(0, op, 4'b0011, 4'b0101);
    w = 0;
    @(negedge clk);
    while ((req_valid & req_ready) == 2'b00 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_val("abort_accept", {31'b0, (req_valid & req_ready) != 2'b00}, 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    check_val("abort_busy_pre", {31'b0, busy}, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_busy", {31'b0, busy}, 0);
    check_val("abort_rsp_valid", {31'b0, rsp_valid}, 0);
    check_val("abort_alu_ctrl", {27'b0, alu_ctrl}, 0);
    prio_model = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0; prio_model = 1'b0;
    req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_req_ready", {30'b0, req_ready}, 0);
    check_val("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    check_val("reset_rsp_id", {31'b0, rsp_id}, 0);
    check_val("reset_rsp_data", {28'b0, rsp_data}, 0);
    check_val("reset_flags", {28'b0, rsp_cout, rsp_zero, rsp_ovf, rsp_err}, 0);
    check_val("reset_busy", {31'b0, busy}, 0);
    check_val("reset_alu_ctrl", {27'b0, alu_ctrl}, 0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst = 1'b0;

    set_req(0, 3'd0, 4'b0011, 4'b0101); serve(0);
    set_req(1, 3'd1, 4'b0101, 4'b0101); serve(0);
    set_req(0, 3'd2, 4'b0011, 4'b0101); serve(1);
    set_req(1, 3'd3, 4'b1111, 4'b0000); serve(0);
    set_req(0, 3'd4, 4'b0000, 4'b0000); serve(0);
    set_req(1, 3'd4, 4'b1000, 4'b0000); serve(0);
    set_req(0, 3'd3, 4'b0111, 4'b0000); serve(0);
    set_req(1, 3'd5, 4'b1010, 4'b0100); serve(0);
    set_req(0, 3'd6, 4'b1001, 4'b0110); serve(0);
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 6));
      ra  = W'($urandom_range(0, (1 << W) - 1));
      rb  = W'($urandom_range(0, (1 << W) - 1));
      set_req(i % 2, rop, ra, rb);
      serve(0);
    end

    // Both requesters held valid; a requester-1 transaction first points priority at 0.
    set_req(1, 3'd6, 4'b0001, 4'b0000); serve(0);
    set_req(0, 3'd0, 4'b0001, 4'b0010);
    set_req(1, 3'd1, 4'b0111, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      serve((k == 1) ? 3 : 0);
      if (k < 3) begin
        if (!req_valid[0]) set_req(0, 3'd0, W'(k + 1), 4'b0011);
        else               set_req(1, 3'd1, W'(k + 5), 4'b0001);
      end
    end
    serve(0);

`ifdef ALU_SEQ_CTRL_MUL_EN
    set_req(0, 3'd7, 4'b0011, 4'b0101); serve(0);
    set_req(1, 3'd7, 4'b1000, 4'b0010); serve(2);
    set_req(0, 3'd7, 4'b0101, 4'b0011); serve(0);
    abort_txn(3'd7);
`else
    set_req(0, 3'd7, 4'b1001, 4'b0110); serve(0);
    set_req(1, 3'd7, 4'b0000, 4'b0000); serve(1);
    abort_txn(3'd0);
`endif
    set_req(0, 3'd0, 4'b0010, 4'b0010);
    set_req(1, 3'd0, 4'b0100, 4'b0100);
    serve(0);
    serve(0);

    check_val("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter BitWidth, default 4, ALU operand/result width.
REQ-002 clk  in  1  single clock, all state on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  2  per-requester request valid (bit0 = requester 0).
REQ-005 req_ready  out  2  per-requester accept; a request transfers when valid and ready are both high.
REQ-006 req0_op, req1_op  in  3 each  opcode.
REQ-007 req0_a, req0_b, req1_a, req1_b  in  BitWidth each  operands.
REQ-008 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-009 rsp_id  out  1  requester that issued the response.
REQ-010 rsp_data  out  BitWidth; rsp_cout, rsp_zero, rsp_ovf, rsp_err  out  1 each  result and flags.
REQ-011 alu_ctrl  out  5  {InvA,InvB,cIn,ORen,FloodCarry} to the RCA ALU.
REQ-012 alu_dina, alu_dinb  out  BitWidth  ALU operands.
REQ-013 alu_dout  in  BitWidth; alu_cout, alu_zero, alu_ovf  in  1 each  combinational ALU outputs.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states IDLE, EXEC, MUL, RESP.
REQ-016 IDLE: req_ready is nonzero only in IDLE, and only the granted bit is set.
REQ-017 Arbitration is round-robin: a single valid requester is granted; if both are valid, grant the one not granted last; after reset requester 0 has priority.
REQ-018 Accepted op, operands and id are latched; next state is EXEC (or MUL for opcode 7 when enabled).
REQ-019 Opcode decode (ctrl, dina, dinb):
- 0 ADD: 00000, A, B
- 1 SUB: 01100, A, B
- 2 RSUB: 10100, A, B
- 3 INC: 00100, A, 0
- 4 DEC: 01000, A, 0
- 5 OR: 00010, A, B
- 6 PASS: 00000, A, 0
REQ-020 FloodCarry (ctrl bit 0) is 0 for every opcode.
REQ-021 EXEC lasts exactly one cycle; alu_dout and the flags are registered into the rsp_* registers at its end; next state is RESP.
REQ-022 RESP: rsp_valid high, response fields stable until rsp_ready is sampled high, then IDLE; no new request is accepted in that same cycle.
REQ-023 Latency: accept in cycle N, rsp_valid high in cycle N+2 for single-cycle ops.
REQ-024 Outside EXEC/MUL, alu_ctrl = 0 and alu_dina = alu_dinb = 0.
REQ-025 rsp_err = 0 for opcodes 0-6.

Reset
REQ-026 rst high at a posedge forces IDLE from any state, including mid-MUL and RESP; any in-flight request is dropped without a response.
REQ-027 Reset values: rsp_valid 0, rsp_id 0, rsp_data 0, all rsp flags 0, req_ready 0 during the reset cycle, busy 0, round-robin pointer to requester 0.

Configuration
REQ-028 Macro ALU_SEQ_CTRL_MUL_EN compiled in: opcode 7 is MUL, an unsigned shift-add multiply using the shared ALU.
- Acc = 0, mcand = A, mplier = B.
- Each MUL cycle: ALU adds acc + mcand (ctrl 00000) if mplier[0] = 1, else PASS acc.
- Acc takes alu_dout; mcand shifts left 1; mplier shifts right 1.
- Exactly BitWidth MUL cycles, then RESP.
- rsp_data = low BitWidth bits of the product.
- rsp_ovf = sticky OR of alu_cout over add cycles OR of bits shifted out of mcand while any later mplier bit is 1.
- rsp_cout = 0; rsp_zero = (rsp_data == 0).
- Latency: accept in cycle N, rsp_valid in cycle N+1+BitWidth.
REQ-029 Macro absent: opcode 7 is illegal and takes the EXEC path with ALU idle; response has rsp_err = 1, rsp_data = 0, all other flags 0; latency as in REQ-023.

Structure
REQ-030 Shared package alu_seq_pkg holds: the opcode enum, the state enum, the 5-bit ctrl bit-position constants, and the per-opcode ctrl constants.
REQ-031 Round-robin arbitration is a single sub-module alu_rr_arb2 (2 requests, grant vector, last-grant register).

Verification
REQ-032 BitWidth 4: req0 ADD A=0011 B=0101 -> at N+2, rsp_data 1000, cout 0, zero 0, id 0.
REQ-033 SUB A=0101 B=0101 -> rsp_data 0000, zero 1, cout 1; RSUB A=0011 B=0101 -> rsp_data 0010.
REQ-034 Both req_valid held for 4 transactions -> grants alternate 0,1,0,1; rsp_ready held low for 3 cycles in RESP -> response fields stable and req_ready = 00 throughout.
REQ-035 MUL_EN: MUL A=0011 B=0101 -> rsp_data 1111, ovf 0, at N+5; MUL A=1000 B=0010 -> rsp_data 0000, ovf 1, zero 1.
REQ-036 No MUL_EN: opcode 7 -> rsp_err 1, rsp_data 0 at N+2.
REQ-037 rst asserted during MUL cycle 2 -> next cycle IDLE, rsp_valid 0, busy 0; a following ADD completes normally with id 0 priority.
